// File: rtl/rotate_left_seq_if.sv
// Handshake bundle for the sequential rotate-left unit: an input word/amount
// channel, a held result channel, and the busy status flag.
interface rotate_left_seq_if #(
   parameter int WIDTH = 4
);
   localparam int AW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [AW-1:0]    in_amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             busy;

   // Upstream/downstream side: supplies words, consumes results.
   modport master (
      output in_valid, in_data, in_amt, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   // Rotator side.
   modport slave (
      input  in_valid, in_data, in_amt, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/rotate_left_seq.sv
// Sequential rotate-left unit. Undoes the upstream rotator by moving the word
// left one position per clock, wrapping the MSB into the LSB, then holds the
// result until downstream takes it. One transaction in flight at a time.
module rotate_left_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   rotate_left_seq_if.slave bus
);
   localparam int AW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] data_q;
   logic [AW-1:0]    cnt_q;

   // State register; reset aborts any transaction in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode. A zero amount skips SHIFT entirely; count==1 marks
   // the final rotation.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = (bus.in_amt == '0) ? DONE : SHIFT;
         SHIFT:   if (cnt_q == AW'(1)) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: inputs are sampled only on acceptance, so garbage on in_data
   // while in_valid is low never reaches the registers. Data is frozen in
   // DONE so backpressure cannot disturb the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  data_q <= bus.in_data;
                  cnt_q  <= bus.in_amt;
               end
            end
            SHIFT: begin
               data_q <= {data_q[WIDTH-2:0], data_q[WIDTH-1]};
               cnt_q  <= cnt_q - AW'(1);
            end
            default: ;
         endcase
      end
   end

   // Status outputs come straight from the state register.
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state == SHIFT) || (state == DONE);
   assign bus.out_data  = data_q;

endmodule

// File: tb/tb_rotate_left_seq.sv
// Self-checking bench for rotate_left_seq (WIDTH=4): directed cases followed
// by random transactions compared against an index-based rotation model.
module tb_rotate_left_seq;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   rotate_left_seq_if #(.WIDTH(W)) bus ();

   rotate_left_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference: result bit i takes source bit (i - amt) mod W.
   function automatic logic [W-1:0] rot_ref(input logic [W-1:0] d, input int amt);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = d[(i - amt + W) % W];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full transaction starting at a negedge with the unit idle. Holds
   // out_ready low for 'hold' cycles once the result appears.
   task automatic xact(input logic [W-1:0] d, input int k, input int hold);
      logic [W-1:0] exp;
      int lat;
      exp = rot_ref(d, k);
      chk("idle_in_ready", 32'(bus.in_ready), 1);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_amt    = 2'(k);
      bus.out_ready = (hold == 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 4'($urandom);
      bus.in_amt   = 2'($urandom);
      lat = 0;
      @(negedge clk);
      while (!bus.out_valid && lat < 20) begin
         chk("shift_busy", 32'(bus.busy), 1);
         chk("shift_in_ready", 32'(bus.in_ready), 0);
         lat++;
         @(negedge clk);
      end
      chk("latency", lat, k);
      chk("result", 32'(bus.out_data), 32'(exp));
      chk("done_in_ready", 32'(bus.in_ready), 0);
      chk("done_busy", 32'(bus.busy), 1);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 4'($urandom);
         @(negedge clk);
         chk("bp_out_valid", 32'(bus.out_valid), 1);
         chk("bp_out_data", 32'(bus.out_data), 32'(exp));
         chk("bp_in_ready", 32'(bus.in_ready), 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("post_out_valid", 32'(bus.out_valid), 0);
      chk("post_in_ready", 32'(bus.in_ready), 1);
      chk("post_busy", 32'(bus.busy), 0);
      chk("post_hold_data", 32'(bus.out_data), 32'(exp));
      bus.out_ready = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_amt    = '0;
      bus.out_ready = 1'b0;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases: basic, wrap, zero amount, backpressure.
      xact(4'b0001, 1, 0);
      xact(4'b1001, 3, 0);
      xact(4'b1000, 2, 0);
      xact(4'b1011, 0, 0);
      xact(4'b0011, 1, 5);

      // Asynchronous reset between edges clears outputs immediately.
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_data", 32'(bus.out_data), 0);
      chk("async_rst_in_ready", 32'(bus.in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset after one SHIFT cycle aborts the word.
      bus.in_valid = 1'b1;
      bus.in_data  = 4'b1110;
      bus.in_amt   = 2'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy_before", 32'(bus.busy), 1);
      rst = 1'b1;
      #1;
      chk("abort_in_ready", 32'(bus.in_ready), 1);
      chk("abort_out_valid", 32'(bus.out_valid), 0);
      chk("abort_busy", 32'(bus.busy), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_output", 32'(bus.out_valid), 0);
      end
      xact(4'b0100, 2, 0);

      // Random transactions with random backpressure.
      for (int n = 0; n < 40; n++)
         xact(4'($urandom), int'($urandom_range(0, W-1)), int'($urandom_range(0, 3)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
